// File: rtl/arithmetic_unit.sv
// Arithmetic slice of the ALU: registered a + {0, b, ~b, all-ones} + carry_in.
// Cascadable through carry_in/carry_out to build wider words from 1-bit slices.
module arithmetic_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);

  logic [WIDTH-1:0] bsel;
  logic [WIDTH:0]   sum;

  always_comb begin
    bsel = '0;
    unique case (operation)
      2'b00:   bsel = '0;
      2'b01:   bsel = b;
      2'b10:   bsel = ~b;
      default: bsel = '1;
    endcase
  end

  // Zero-extended adder, so sum[WIDTH] is a plain adder carry (1 = no borrow on subtract).
  always_comb begin
    sum = {1'b0, a} + {1'b0, bsel} + {{WIDTH{1'b0}}, carry_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      carry_out <= 1'b0;
    end else begin
      out       <= sum[WIDTH-1:0];
      carry_out <= sum[WIDTH];
    end
  end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Bench for the 1-bit arithmetic slice: reset, exhaustive sweep, spot checks,
// random back-to-back traffic with latency/stability checks and a mid-stream reset.
module tb_arithmetic_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] a;
  logic [0:0] b;
  logic       carry_in;
  logic [1:0] operation;
  logic [0:0] out;
  logic       carry_out;

  logic [1:0] exp_q[$];
  logic [1:0] prev_exp;
  logic [1:0] got;
  int         checks = 0;
  int         errors = 0;

  arithmetic_unit #(.WIDTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .operation (operation),
    .out       (out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Reference: {carry, sum} of a + selected B form + carry_in.
  function automatic logic [1:0] model(logic av, logic bv, logic cv, logic [1:0] op);
    int bs;
    int s;
    case (op)
      2'd0:    bs = 0;
      2'd1:    bs = int'(bv);
      2'd2:    bs = bv ? 0 : 1;
      default: bs = 1;
    endcase
    s = int'(av) + bs + int'(cv);
    return s[1:0];
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic bv, input logic cv, input logic [1:0] op);
    @(negedge clk);
    a = av; b = bv; carry_in = cv; operation = op;
    exp_q.push_back(model(av, bv, cv, op));
  endtask

  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed result expected none queued", tag);
    end
    if (exp_q.size() > 0) begin
      prev_exp = exp_q.pop_front();
      check(tag, {carry_out, out}, prev_exp);
    end
  endtask

  task automatic step(input logic av, input logic bv, input logic cv, input logic [1:0] op,
                      input string tag);
    drive(av, bv, cv, op);
    collect(tag);
  endtask

  initial begin
    rst = 1'b1; a = 1'b1; b = 1'b1; carry_in = 1'b1; operation = 2'b01;
    #1;
    check("reset_initial", {carry_out, out}, 2'b00);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", {carry_out, out}, 2'b00);
    end
    @(negedge clk);
    rst = 1'b0;

    // Async assertion: get a nonzero result, then raise rst between edges.
    step(1'b1, 1'b1, 1'b1, 2'b01, "pre_async");
    #1 rst = 1'b1;
    #1 check("async_clear", {carry_out, out}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();

    for (int op = 0; op < 4; op++)
      for (int c = 0; c < 2; c++)
        for (int ai = 0; ai < 2; ai++)
          for (int bi = 0; bi < 2; bi++)
            step(ai[0], bi[0], c[0], op[1:0], "sweep");

    step(1'b1, 1'b1, 1'b1, 2'b01, "code011_a1_b1");
    check("code011_a1_b1_const", {carry_out, out}, 2'b11);
    step(1'b1, 1'b0, 1'b0, 2'b00, "code000_a1");
    check("code000_a1_const", {carry_out, out}, 2'b01);
    step(1'b1, 1'b0, 1'b1, 2'b10, "sub_a1_b0");
    check("sub_a1_b0_const", {carry_out, out}, 2'b11);
    step(1'b0, 1'b0, 1'b1, 2'b10, "sub_a0_b0");
    check("sub_a0_b0_const", {carry_out, out}, 2'b10);
    step(1'b0, 1'b1, 1'b1, 2'b10, "sub_a0_b1");
    check("sub_a0_b1_const", {carry_out, out}, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b11, "dec_a0");
    check("dec_a0_const", {carry_out, out}, 2'b01);
    step(1'b1, 1'b0, 1'b0, 2'b11, "dec_a1");
    check("dec_a1_const", {carry_out, out}, 2'b10);
    step(1'b0, 1'b1, 1'b1, 2'b11, "code111_a0");
    check("code111_a0_const", {carry_out, out}, 2'b10);
    step(1'b1, 1'b0, 1'b1, 2'b11, "code111_a1");
    check("code111_a1_const", {carry_out, out}, 2'b11);

    // Random back-to-back traffic; outputs must hold until the next edge.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      check("hold_after_drive", {carry_out, out}, prev_exp);
      #2 a = ~a;
      #1 check("hold_mid_cycle", {carry_out, out}, prev_exp);
      a = ~a;
      collect("random");
      if (i == 20) begin
        #1 rst = 1'b1;
        #1 check("midstream_clear", {carry_out, out}, 2'b00);
        exp_q.delete();
        prev_exp = 2'b00;
        #1 rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
